// File: rtl/xalu.sv
// Execute-stage ALU with registered one-hot opcode and an iterative
// radix-2 multiply/divide unit that owns the HI/LO registers.
module xalu #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5,
  parameter bit          MDU_EN  = 1'b1
) (
  input  logic               SYSCLK,
  input  logic               RESET_D2_R_N,
  input  logic               CLMI_RHOLD,
  input  logic [WIDTH-1:0]   REGA_E_R,
  input  logic [WIDTH-1:0]   REGBI_E_R,
  input  logic [15:0]        ALUOP_E_P,
  input  logic [3:0]         MDOP_E_P,
  input  logic [WIDTH-1:0]   LINK_E_R,
  output logic [WIDTH-1:0]   ALURES_E,
  output logic               V_E,
  output logic               ALU_ERR,
  output logic               MD_BUSY,
  output logic               MD_STALL,
  output logic [WIDTH-1:0]   HI_R,
  output logic [WIDTH-1:0]   LO_R
);

  localparam int unsigned OP_ADD  = 0;
  localparam int unsigned OP_SUB  = 1;
  localparam int unsigned OP_SLTS = 2;
  localparam int unsigned OP_SLTU = 3;
  localparam int unsigned OP_AND  = 4;
  localparam int unsigned OP_OR   = 5;
  localparam int unsigned OP_XOR  = 6;
  localparam int unsigned OP_NOR  = 7;
  localparam int unsigned OP_SLL  = 8;
  localparam int unsigned OP_SRL  = 9;
  localparam int unsigned OP_SRA  = 10;
  localparam int unsigned OP_LUI  = 11;
  localparam int unsigned OP_LINK = 12;
  localparam int unsigned OP_MFHI = 13;
  localparam int unsigned OP_MFLO = 14;
  localparam int unsigned OP_ROTR = 15;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

  logic [15:0] aluop_q;
  logic [3:0]  mdop_q;

  always_ff @(posedge SYSCLK or negedge RESET_D2_R_N) begin
    if (!RESET_D2_R_N) begin
      aluop_q <= 16'h0001;
      mdop_q  <= '0;
    end else if (!CLMI_RHOLD) begin
      aluop_q <= ALUOP_E_P;
      mdop_q  <= MDOP_E_P;
    end
  end

  // ---------------- ALU ----------------
  logic [SHAMT_W-1:0] sh;
  logic [SHAMT_W:0]   inv_sh;
  logic               is_sub;
  logic [WIDTH-1:0]   b_eff;
  logic [WIDTH:0]     sum;
  logic               op_valid;
  logic [WIDTH-1:0]   res [16];

  assign sh       = REGA_E_R[SHAMT_W-1:0];
  assign inv_sh   = (SHAMT_W+1)'(WIDTH) - {1'b0, sh};
  assign is_sub   = aluop_q[OP_SUB];
  assign b_eff    = is_sub ? ~REGBI_E_R : REGBI_E_R;
  assign sum      = {1'b0, REGA_E_R} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
  assign op_valid = (aluop_q != '0) && ((aluop_q & (aluop_q - 16'd1)) == '0);

  always_comb begin
    res[OP_ADD]  = sum[WIDTH-1:0];
    res[OP_SUB]  = sum[WIDTH-1:0];
    res[OP_SLTS] = WIDTH'($signed(REGA_E_R) < $signed(REGBI_E_R));
    res[OP_SLTU] = WIDTH'(REGA_E_R < REGBI_E_R);
    res[OP_AND]  = REGA_E_R & REGBI_E_R;
    res[OP_OR]   = REGA_E_R | REGBI_E_R;
    res[OP_XOR]  = REGA_E_R ^ REGBI_E_R;
    res[OP_NOR]  = ~(REGA_E_R | REGBI_E_R);
    res[OP_SLL]  = REGBI_E_R << sh;
    res[OP_SRL]  = REGBI_E_R >> sh;
    res[OP_SRA]  = WIDTH'($signed(REGBI_E_R) >>> sh);
    res[OP_LUI]  = REGBI_E_R << (WIDTH/2);
    res[OP_LINK] = LINK_E_R;
    res[OP_MFHI] = HI_R;
    res[OP_MFLO] = LO_R;
    // sh=0 gives inv_sh=WIDTH, so the left term shifts out entirely
    res[OP_ROTR] = (REGBI_E_R >> sh) | (REGBI_E_R << inv_sh);
  end

  always_comb begin
    ALURES_E = '0;
    if (op_valid) begin
      for (int unsigned i = 0; i < 16; i++) begin
        if (aluop_q[i]) ALURES_E = ALURES_E | res[i];
      end
    end
  end

  assign V_E = op_valid && (aluop_q[OP_ADD] || aluop_q[OP_SUB]) &&
               ((REGA_E_R[WIDTH-1] ^ b_eff[WIDTH-1] ^ sum[WIDTH-1]) ^ sum[WIDTH]);
  assign ALU_ERR = !op_valid;

  // ---------------- MDU ----------------
  generate
    if (MDU_EN) begin : g_mdu
      md_state_e          state_q, state_d;
      logic [SHAMT_W-1:0] cnt_q, cnt_d;
      logic [2*WIDTH-1:0] acc_q, acc_d;
      logic [WIDTH-1:0]   opb_q, opb_d;
      logic               is_div_q, is_div_d;
      logic               neg_a_q, neg_a_d;
      logic               neg_b_q, neg_b_d;
      logic               b_zero_q, b_zero_d;
      logic [WIDTH-1:0]   hi_q, hi_d;
      logic [WIDTH-1:0]   lo_q, lo_d;

      logic               st_signed, st_div, st_neg_a, st_neg_b;
      logic [WIDTH-1:0]   a_mag, b_mag;
      logic [WIDTH:0]     madd;
      logic [WIDTH:0]     rem_sh;
      logic [WIDTH-1:0]   rem_sub;
      logic [2*WIDTH-1:0] prod_neg;

      assign st_signed = mdop_q[0] | mdop_q[2];
      assign st_div    = mdop_q[2] | mdop_q[3];
      assign st_neg_a  = st_signed & REGA_E_R[WIDTH-1];
      assign st_neg_b  = st_signed & REGBI_E_R[WIDTH-1];
      assign a_mag     = st_neg_a ? -REGA_E_R : REGA_E_R;
      assign b_mag     = st_neg_b ? -REGBI_E_R : REGBI_E_R;

      assign madd     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
      assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      // remainder stays below the divisor, so the W-bit difference is exact
      assign rem_sub  = rem_sh[WIDTH-1:0] - opb_q;
      assign prod_neg = -acc_q;

      always_ff @(posedge SYSCLK or negedge RESET_D2_R_N) begin
        if (!RESET_D2_R_N) begin
          state_q  <= MD_IDLE;
          cnt_q    <= '0;
          acc_q    <= '0;
          opb_q    <= '0;
          is_div_q <= 1'b0;
          neg_a_q  <= 1'b0;
          neg_b_q  <= 1'b0;
          b_zero_q <= 1'b0;
          hi_q     <= '0;
          lo_q     <= '0;
        end else begin
          state_q  <= state_d;
          cnt_q    <= cnt_d;
          acc_q    <= acc_d;
          opb_q    <= opb_d;
          is_div_q <= is_div_d;
          neg_a_q  <= neg_a_d;
          neg_b_q  <= neg_b_d;
          b_zero_q <= b_zero_d;
          hi_q     <= hi_d;
          lo_q     <= lo_d;
        end
      end

      always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        is_div_d = is_div_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        b_zero_d = b_zero_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        unique case (state_q)
          MD_IDLE: begin
            if ((mdop_q != '0) && !CLMI_RHOLD) begin
              state_d  = MD_RUN;
              cnt_d    = SHAMT_W'(WIDTH-1);
              acc_d    = {{WIDTH{1'b0}}, a_mag};
              opb_d    = b_mag;
              is_div_d = st_div;
              neg_a_d  = st_neg_a;
              neg_b_d  = st_neg_b;
              b_zero_d = (REGBI_E_R == '0);
            end
          end
          MD_RUN: begin
            if (is_div_q) begin
              if (rem_sh >= {1'b0, opb_q})
                acc_d = {rem_sub, acc_q[WIDTH-2:0], 1'b1};
              else
                acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end else begin
              acc_d = {madd, acc_q[WIDTH-1:1]};
            end
            cnt_d = cnt_q - SHAMT_W'(1);
            if (cnt_q == '0) state_d = MD_FIX;
          end
          MD_FIX: begin
            if (is_div_q) begin
              lo_d = (neg_a_q ^ neg_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
              hi_d = neg_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
              if (b_zero_q) lo_d = '1;
            end else begin
              {hi_d, lo_d} = (neg_a_q ^ neg_b_q) ? prod_neg : acc_q;
            end
            state_d = MD_IDLE;
          end
          default: state_d = MD_IDLE;
        endcase
      end

      assign MD_BUSY  = (state_q != MD_IDLE);
      assign MD_STALL = MD_BUSY & (aluop_q[OP_MFHI] | aluop_q[OP_MFLO] | (mdop_q != '0));
      assign HI_R     = hi_q;
      assign LO_R     = lo_q;
    end else begin : g_no_mdu
      assign MD_BUSY  = 1'b0;
      assign MD_STALL = 1'b0;
      assign HI_R     = '0;
      assign LO_R     = '0;
    end
  endgenerate

endmodule

// File: tb/tb_xalu.sv
// Directed-vector bench for xalu at WIDTH=32 with hand-computed expectations.
module tb_xalu;

  logic        SYSCLK = 1'b0;
  logic        RESET_D2_R_N;
  logic        CLMI_RHOLD;
  logic [31:0] REGA_E_R, REGBI_E_R, LINK_E_R;
  logic [15:0] ALUOP_E_P;
  logic [3:0]  MDOP_E_P;
  logic [31:0] ALURES_E, HI_R, LO_R;
  logic        V_E, ALU_ERR, MD_BUSY, MD_STALL;

  int n_cmp = 0;
  int n_bad = 0;

  xalu #(.WIDTH(32), .SHAMT_W(5), .MDU_EN(1'b1)) dut (
    .SYSCLK(SYSCLK), .RESET_D2_R_N(RESET_D2_R_N), .CLMI_RHOLD(CLMI_RHOLD),
    .REGA_E_R(REGA_E_R), .REGBI_E_R(REGBI_E_R), .ALUOP_E_P(ALUOP_E_P),
    .MDOP_E_P(MDOP_E_P), .LINK_E_R(LINK_E_R), .ALURES_E(ALURES_E), .V_E(V_E),
    .ALU_ERR(ALU_ERR), .MD_BUSY(MD_BUSY), .MD_STALL(MD_STALL),
    .HI_R(HI_R), .LO_R(LO_R)
  );

  always #5 SYSCLK = ~SYSCLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge SYSCLK);
    #1;
  endtask

  task automatic alu_vec(input string tag, input int op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_r, input logic exp_v);
    REGA_E_R  = a;
    REGBI_E_R = b;
    ALUOP_E_P = 16'(1) << op;
    tick();
    check(tag, ALURES_E, exp_r);
    check({tag, "_v"}, V_E, exp_v);
  endtask

  // Launch an MDU op, optionally hold during iteration, and check latency and HI/LO.
  task automatic md_run(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [15:0] aluop, input logic hold_run,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    int stall_bad;
    logic mf;
    mf = aluop[13] | aluop[14];
    ALUOP_E_P = aluop;
    REGA_E_R  = a;
    REGBI_E_R = b;
    MDOP_E_P  = op;
    tick();
    MDOP_E_P  = 4'b0000;
    tick();
    CLMI_RHOLD = hold_run;
    n = 0;
    stall_bad = 0;
    while (MD_BUSY && n < 200) begin
      n++;
      if (mf && !MD_STALL) stall_bad++;
      tick();
    end
    CLMI_RHOLD = 1'b0;
    check({tag, "_lat"}, n, 33);
    check({tag, "_hi"}, HI_R, exp_hi);
    check({tag, "_lo"}, LO_R, exp_lo);
    if (mf) begin
      check({tag, "_stall"}, stall_bad, 0);
      check({tag, "_stall_off"}, MD_STALL, 1'b0);
      check({tag, "_mf"}, ALURES_E, aluop[14] ? exp_lo : exp_hi);
    end
  endtask

  initial begin
    RESET_D2_R_N = 1'b0;
    CLMI_RHOLD   = 1'b0;
    REGA_E_R     = 32'd3;
    REGBI_E_R    = 32'd4;
    LINK_E_R     = 32'h0040_1234;
    ALUOP_E_P    = 16'h0000;
    MDOP_E_P     = 4'b0000;
    #12;
    check("rst_res", ALURES_E, 32'd7);
    check("rst_err", ALU_ERR, 1'b0);
    check("rst_busy", MD_BUSY, 1'b0);
    check("rst_hi", HI_R, 32'd0);
    check("rst_lo", LO_R, 32'd0);
    @(negedge SYSCLK);
    RESET_D2_R_N = 1'b1;

    alu_vec("add_ovf", 0,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1);
    alu_vec("sub",     1,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
    alu_vec("sub_ovf", 1,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1);
    alu_vec("slts",    2,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0);
    alu_vec("sltu",    3,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0);
    alu_vec("and",     4,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0);
    alu_vec("or",      5,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0);
    alu_vec("xor",     6,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0);
    alu_vec("nor",     7,  32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0);
    alu_vec("sll",     8,  32'h0000_0004, 32'h0000_0001, 32'h0000_0010, 1'b0);
    alu_vec("srl",     9,  32'h0000_0004, 32'h8000_0000, 32'h0800_0000, 1'b0);
    alu_vec("sra",     10, 32'h0000_001F, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    alu_vec("lui",     11, 32'h0000_0000, 32'h0000_ABCD, 32'hABCD_0000, 1'b0);
    alu_vec("link",    12, 32'h0000_0000, 32'h0000_0000, 32'h0040_1234, 1'b0);
    alu_vec("rotr4",   15, 32'h0000_0004, 32'h1234_5678, 32'h8123_4567, 1'b0);
    alu_vec("rotr0",   15, 32'h0000_0020, 32'h1234_5678, 32'h1234_5678, 1'b0);

    // Opcode hold: result must stay at XOR while ALUOP_E_P changes
    alu_vec("hold_pre", 6, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 1'b0);
    CLMI_RHOLD = 1'b1;
    ALUOP_E_P = 16'h0010; tick(); check("hold1", ALURES_E, 32'h0000_0FF0);
    ALUOP_E_P = 16'h0020; tick(); check("hold2", ALURES_E, 32'h0000_0FF0);
    ALUOP_E_P = 16'h0002; tick(); check("hold3", ALURES_E, 32'h0000_0FF0);
    CLMI_RHOLD = 1'b0;
    ALUOP_E_P = 16'h0010; tick(); check("hold_rel", ALURES_E, 32'h0000_F000);

    md_run("mult",  4'b0001, 32'hFFFF_FFFE, 32'h0000_0003, 16'h4000, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    md_run("multu", 4'b0010, 32'hFFFF_FFFF, 32'h0000_0002, 16'h2000, 1'b0, 32'h0000_0001, 32'hFFFF_FFFE);
    md_run("divu0", 4'b1000, 32'h0000_0007, 32'h0000_0000, 16'h0001, 1'b1, 32'h0000_0007, 32'hFFFF_FFFF);
    md_run("divmn", 4'b0100, 32'h8000_0000, 32'hFFFF_FFFF, 16'h0001, 1'b0, 32'h0000_0000, 32'h8000_0000);
    md_run("div",   4'b0100, 32'hFFFF_FFF9, 32'h0000_0002, 16'h4000, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    // Asynchronous reset mid-iteration, away from any clock edge
    ALUOP_E_P = 16'h0001;
    REGA_E_R  = 32'd5;
    REGBI_E_R = 32'd7;
    MDOP_E_P  = 4'b0010;
    tick();
    MDOP_E_P  = 4'b0000;
    repeat (6) tick();
    check("mid_busy", MD_BUSY, 1'b1);
    ALUOP_E_P = 16'h0008;
    #3;
    RESET_D2_R_N = 1'b0;
    #1;
    check("arst_busy", MD_BUSY, 1'b0);
    check("arst_hi", HI_R, 32'd0);
    check("arst_lo", LO_R, 32'd0);
    check("arst_res", ALURES_E, 32'd12);
    @(negedge SYSCLK);
    RESET_D2_R_N = 1'b1;
    repeat (40) tick();
    check("arst_stay", MD_BUSY, 1'b0);
    check("arst_lo2", LO_R, 32'd0);

    alu_vec("err_zero", 0, 32'd1, 32'd2, 32'd3, 1'b0);
    ALUOP_E_P = 16'h0000; tick();
    check("err0_flag", ALU_ERR, 1'b1);
    check("err0_res", ALURES_E, 32'd0);
    ALUOP_E_P = 16'h0003; tick();
    check("err2_flag", ALU_ERR, 1'b1);
    check("err2_res", ALURES_E, 32'd0);
    check("err2_v", V_E, 1'b0);
    ALUOP_E_P = 16'h0001; tick();
    check("err_clr", ALU_ERR, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
